// File: rtl/line_rasterizer_if.sv
// Clipper-to-rasterizer line request bus plus rasterizer-to-framebuffer pixel bus.
// master = rasterizer side, slave = clipper/framebuffer side.
interface line_rasterizer_if #(
   parameter int COORD_W = 10,
   parameter int COLOR_W = 3
);
   // Handshakes: a line is transferred in a cycle where vld is high while the
   // rasterizer is waiting after its raster_ready pulse; a pixel is transferred
   // on every rising clk edge where px_vld && px_rdy, and while px_vld && !px_rdy
   // the pixel fields (px_x, px_y, px_color, px_last) stay unchanged.
   logic [COORD_W-1:0] x0_in;
   logic [COORD_W-1:0] y0_in;
   logic [COORD_W-1:0] x1_in;
   logic [COORD_W-1:0] y1_in;
   logic [COLOR_W-1:0] color_in;
   logic               vld;
   logic               end_of_obj;
   logic               raster_ready;
   logic [COORD_W-1:0] px_x;
   logic [COORD_W-1:0] px_y;
   logic [COLOR_W-1:0] px_color;
   logic               px_vld;
   logic               px_rdy;
   logic               px_last;

   modport master (
      input  x0_in, y0_in, x1_in, y1_in, color_in, vld, end_of_obj, px_rdy,
      output raster_ready, px_x, px_y, px_color, px_vld, px_last
   );

   modport slave (
      output x0_in, y0_in, x1_in, y1_in, color_in, vld, end_of_obj, px_rdy,
      input  raster_ready, px_x, px_y, px_color, px_vld, px_last
   );
endinterface

// File: rtl/line_rasterizer.sv
// Requests clipped lines one at a time and walks each with integer Bresenham,
// emitting one pixel per cycle under px_rdy backpressure.
module line_rasterizer #(
   parameter int COORD_W  = 10,
   parameter int COLOR_W  = 3,
   parameter int WAIT_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  frame_start,
   line_rasterizer_if.master     bus,
   output logic                  busy,
   output logic [15:0]           line_cnt,
   output logic [2:0]            state_dbg,
   output logic                  line_eoo
);

   localparam int W2   = COORD_W + 2;
   localparam int W3   = COORD_W + 3;
   localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_SETUP = 3'd3,
      S_DRAW  = 3'd4
   } state_t;

   state_t state, next_state;

   logic [WC_W-1:0]    wait_cnt;
   logic [COORD_W-1:0] cap_x0, cap_y0, cap_x1, cap_y1;
   logic [COLOR_W-1:0] cap_color;
   logic               cap_eoo;
   logic [COORD_W-1:0] cur_x, cur_y;
   logic signed [W2-1:0] dx, dy, err;
   logic               sx_neg, sy_neg;

   logic               wait_done;
   logic               at_end;
   logic               last_hs;
   logic signed [W2-1:0] diff_x, diff_y, abs_x, abs_y;
   logic signed [W3-1:0] e2, dx_e, dy_e;
   logic               step_x, step_y;
   logic signed [W2-1:0] err_step;
   logic [COORD_W-1:0] x_inc, y_inc;

   assign wait_done = (wait_cnt == WC_W'(WAIT_MAX - 1));
   assign at_end    = (cur_x == cap_x1) && (cur_y == cap_y1);
   assign last_hs   = (state == S_DRAW) && bus.px_rdy && at_end;

   // Setup arithmetic works on zero-extended coordinates so the difference never wraps.
   assign diff_x = signed'({2'b00, cap_x1}) - signed'({2'b00, cap_x0});
   assign diff_y = signed'({2'b00, cap_y1}) - signed'({2'b00, cap_y0});
   assign abs_x  = diff_x[W2-1] ? -diff_x : diff_x;
   assign abs_y  = diff_y[W2-1] ? -diff_y : diff_y;

   // Both step decisions use the error term from before this step.
   assign e2       = {err, 1'b0};
   assign dx_e     = {dx[W2-1], dx};
   assign dy_e     = {dy[W2-1], dy};
   assign step_x   = (e2 >= dy_e);
   assign step_y   = (e2 <= dx_e);
   assign err_step = err + (step_x ? dy : W2'(0)) + (step_y ? dx : W2'(0));
   assign x_inc    = sx_neg ? {COORD_W{1'b1}} : COORD_W'(1);
   assign y_inc    = sy_neg ? {COORD_W{1'b1}} : COORD_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (en) next_state = S_REQ;
         S_REQ:   next_state = S_WAIT;
         S_WAIT: begin
            if (bus.vld)        next_state = S_SETUP;
            else if (wait_done) next_state = en ? S_REQ : S_IDLE;
         end
         S_SETUP: next_state = S_DRAW;
         S_DRAW:  if (bus.px_rdy && at_end) next_state = en ? S_REQ : S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Pixel fields come straight from registers that only move on a handshake.
   always_comb begin
      bus.raster_ready = (state == S_REQ);
      bus.px_vld       = (state == S_DRAW);
      bus.px_last      = (state == S_DRAW) && at_end;
      bus.px_x         = cur_x;
      bus.px_y         = cur_y;
      bus.px_color     = cap_color;
      busy             = (state != S_IDLE);
      state_dbg        = state;
      line_eoo         = cap_eoo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         cap_x0    <= '0;
         cap_y0    <= '0;
         cap_x1    <= '0;
         cap_y1    <= '0;
         cap_color <= '0;
         cap_eoo   <= 1'b0;
         cur_x     <= '0;
         cur_y     <= '0;
         dx        <= '0;
         dy        <= '0;
         err       <= '0;
         sx_neg    <= 1'b0;
         sy_neg    <= 1'b0;
      end else begin
         case (state)
            S_REQ: wait_cnt <= '0;
            S_WAIT: begin
               if (bus.vld) begin
                  cap_x0    <= bus.x0_in;
                  cap_y0    <= bus.y0_in;
                  cap_x1    <= bus.x1_in;
                  cap_y1    <= bus.y1_in;
                  cap_color <= bus.color_in;
                  cap_eoo   <= bus.end_of_obj;
               end else if (!wait_done) begin
                  wait_cnt <= wait_cnt + WC_W'(1);
               end
            end
            S_SETUP: begin
               dx     <= abs_x;
               dy     <= -abs_y;
               err    <= abs_x - abs_y;
               sx_neg <= !(cap_x0 < cap_x1);
               sy_neg <= !(cap_y0 < cap_y1);
               cur_x  <= cap_x0;
               cur_y  <= cap_y0;
            end
            S_DRAW: begin
               if (bus.px_rdy && !at_end) begin
                  err <= err_step;
                  if (step_x) cur_x <= cur_x + x_inc;
                  if (step_y) cur_y <= cur_y + y_inc;
               end
            end
            default: ;
         endcase
      end
   end

   // A frame_start in the same cycle as a line completion wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           line_cnt <= '0;
      else if (frame_start) line_cnt <= '0;
      else if (last_hs)     line_cnt <= line_cnt + 16'd1;
   end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: a clipper driver feeds lines, a monitor
// pops expected pixels from a queue and also checks stability under stall.
module tb_line_rasterizer;

   localparam int PW = 24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        frame_start;
   logic        busy;
   logic [15:0] line_cnt;
   logic [2:0]  state_dbg;
   logic        line_eoo;

   int checks = 0;
   int errors = 0;
   logic [PW-1:0] exp_q[$];
   bit ignore_px = 1'b0;

   line_rasterizer_if #(.COORD_W(10), .COLOR_W(3)) bus ();

   line_rasterizer #(.COORD_W(10), .COLOR_W(3), .WAIT_MAX(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .frame_start (frame_start),
      .bus         (bus.master),
      .busy        (busy),
      .line_cnt    (line_cnt),
      .state_dbg   (state_dbg),
      .line_eoo    (line_eoo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [PW-1:0] pk(input int x, input int y, input int c, input bit last);
      return {10'(x), 10'(y), 3'(c), last};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_rr(input int budget);
      int n = 0;
      @(negedge clk);
      while (!bus.raster_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bus.raster_ready) begin
         errors++;
         $display("FAIL raster_ready_timeout: got 0 expected 1 within %0d cycles", budget);
      end
   endtask

   // Clipper model: answer a raster_ready pulse with vld two cycles later.
   // Returns one cycle after vld, i.e. in the SETUP cycle.
   task automatic send_line(input int x0, input int y0, input int x1, input int y1, input int c);
      wait_rr(20);
      tick;
      tick;
      bus.x0_in      = 10'(x0);
      bus.y0_in      = 10'(y0);
      bus.x1_in      = 10'(x1);
      bus.y1_in      = 10'(y1);
      bus.color_in   = 3'(c);
      bus.end_of_obj = 1'b1;
      bus.vld        = 1'b1;
      tick;
      bus.vld        = 1'b0;
      bus.end_of_obj = 1'b0;
   endtask

   task automatic wait_drained(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pixels outstanding expected 0", exp_q.size());
      end
   endtask

   // Monitor: one comparison per handshake, plus a hold check after every stall.
   logic [PW-1:0] held;
   bit            stalled = 1'b0;
   always @(negedge clk) begin
      logic [PW-1:0] act;
      logic [PW-1:0] exp;
      act = {bus.px_x, bus.px_y, bus.px_color, bus.px_last};
      if (rst_n && !ignore_px) begin
         if (stalled) begin
            checks++;
            if (!bus.px_vld || act !== held) begin
               errors++;
               $display("FAIL px_hold: got vld=%0d px=%h expected vld=1 px=%h", bus.px_vld, act, held);
            end
         end
         if (bus.px_vld && bus.px_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL px_extra: got px=%h expected no pixel", act);
            end else begin
               exp = exp_q.pop_front();
               if (act !== exp) begin
                  errors++;
                  $display("FAIL px_data: got x=%0d y=%0d c=%0d last=%0d expected x=%0d y=%0d c=%0d last=%0d",
                           act[23:14], act[13:4], act[3:1], act[0], exp[23:14], exp[13:4], exp[3:1], exp[0]);
               end
            end
         end
         stalled = bus.px_vld && !bus.px_rdy;
         held    = act;
      end else begin
         stalled = 1'b0;
      end
   end

   initial begin
      int n;
      rst_n          = 1'b0;
      en             = 1'b0;
      frame_start    = 1'b0;
      bus.x0_in      = '0;
      bus.y0_in      = '0;
      bus.x1_in      = '0;
      bus.y1_in      = '0;
      bus.color_in   = '0;
      bus.vld        = 1'b0;
      bus.end_of_obj = 1'b0;
      bus.px_rdy     = 1'b1;
      tick;
      tick;
      chk("rst_raster_ready", bus.raster_ready, 0);
      chk("rst_px_vld", bus.px_vld, 0);
      chk("rst_px_last", bus.px_last, 0);
      chk("rst_px_xy", {bus.px_x, bus.px_y}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_line_cnt", line_cnt, 0);
      rst_n = 1'b1;
      tick;
      tick;
      chk("idle_no_en_state", state_dbg, 0);
      chk("idle_no_en_rr", bus.raster_ready, 0);

      // Horizontal line, checking first-pixel latency and the re-request.
      en = 1'b1;
      exp_q.push_back(pk(0, 0, 5, 0));
      exp_q.push_back(pk(1, 0, 5, 0));
      exp_q.push_back(pk(2, 0, 5, 0));
      exp_q.push_back(pk(3, 0, 5, 1));
      send_line(0, 0, 3, 0, 5);
      chk("setup_state", state_dbg, 3);
      chk("setup_px_vld", bus.px_vld, 0);
      chk("setup_eoo", line_eoo, 1);
      tick;
      chk("first_px_vld", bus.px_vld, 1);
      wait_drained(40);
      chk("horiz_rr_again", bus.raster_ready, 1);
      chk("horiz_line_cnt", line_cnt, 1);

      // Steep line; a vld during SETUP/DRAW must not disturb it.
      exp_q.push_back(pk(0, 0, 1, 0));
      exp_q.push_back(pk(0, 1, 1, 0));
      exp_q.push_back(pk(1, 2, 1, 0));
      exp_q.push_back(pk(1, 3, 1, 1));
      send_line(0, 0, 1, 3, 1);
      bus.x0_in = 10'd500;
      bus.x1_in = 10'd7;
      bus.color_in = 3'd6;
      bus.vld = 1'b1;
      tick;
      tick;
      bus.vld = 1'b0;
      wait_drained(40);
      chk("steep_line_cnt", line_cnt, 2);

      exp_q.push_back(pk(5, 5, 6, 0));
      exp_q.push_back(pk(4, 4, 6, 0));
      exp_q.push_back(pk(3, 3, 6, 0));
      exp_q.push_back(pk(2, 2, 6, 1));
      send_line(5, 5, 2, 2, 6);
      wait_drained(40);

      // Backpressure on the second pixel for three cycles.
      exp_q.push_back(pk(10, 7, 2, 0));
      exp_q.push_back(pk(11, 7, 2, 0));
      exp_q.push_back(pk(12, 7, 2, 0));
      exp_q.push_back(pk(13, 7, 2, 1));
      send_line(10, 7, 13, 7, 2);
      tick;
      tick;
      bus.px_rdy = 1'b0;
      chk("bp_px_x_start", bus.px_x, 11);
      tick;
      tick;
      chk("bp_px_x_held", bus.px_x, 11);
      chk("bp_px_vld_held", bus.px_vld, 1);
      tick;
      bus.px_rdy = 1'b1;
      wait_drained(40);
      chk("bp_line_cnt", line_cnt, 4);

      // No vld: raster_ready must re-pulse every WAIT_MAX+1 cycles.
      for (int k = 0; k < 2; k++) begin
         wait_rr(10);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.raster_ready && n < 20);
         chk("rr_period", n, 5);
      end

      // Single point at the coordinate limit, frame_start on its completion.
      exp_q.push_back(pk(1023, 1023, 7, 1));
      send_line(1023, 1023, 1023, 1023, 7);
      chk("pt_line_cnt_before", line_cnt, 4);
      tick;
      chk("pt_px_last", bus.px_last, 1);
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      chk("pt_frame_start_clear", line_cnt, 0);
      chk("pt_rr_again", bus.raster_ready, 1);
      wait_drained(5);

      // Asynchronous reset in the middle of a long line.
      ignore_px = 1'b1;
      send_line(0, 0, 100, 0, 3);
      for (int k = 0; k < 5; k++) tick;
      chk("pre_rst_px_vld", bus.px_vld, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_px_vld", bus.px_vld, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_px_xy", {bus.px_x, bus.px_y}, 0);
      chk("async_rst_px_color", bus.px_color, 0);
      chk("async_rst_state", state_dbg, 0);
      tick;
      tick;
      rst_n = 1'b1;
      ignore_px = 1'b0;
      chk("post_rst_idle", state_dbg, 0);
      tick;
      chk("post_rst_req", bus.raster_ready, 1);

      // Fresh line after reset, with en dropped mid-line.
      exp_q.push_back(pk(2, 3, 4, 0));
      exp_q.push_back(pk(3, 4, 4, 0));
      exp_q.push_back(pk(3, 5, 4, 1));
      send_line(2, 3, 3, 5, 4);
      en = 1'b0;
      wait_drained(40);
      chk("en_off_state_idle", state_dbg, 0);
      chk("en_off_busy", busy, 0);
      chk("en_off_line_cnt", line_cnt, 1);
      tick;
      tick;
      chk("en_off_no_rr", bus.raster_ready, 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
